calc_sequencer: RTL and testbench
=================================

CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 SHALL have parameter W, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SETTLE, default 1, range 1-15, number of cycles the operands are held on the calculator before the result is sampled.
REQ-003 SHALL have port clk  input  1  the only clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous reset, active-high.
REQ-005 SHALL have port cmd_valid  input  1  command present.
REQ-006 SHALL have port cmd_ready  output  1  block accepts a command.
REQ-007 SHALL have port cmd_op  input  3  opcode, encoded as 000 A+B, 001 A-B, 01x abs(B), 100 B+A, 101 B-A, 11x abs(A).
REQ-008 SHALL have port cmd_a  input  W  operand A.
REQ-009 SHALL have port cmd_b  input  W  operand B.
REQ-010 SHALL have port cmd_acc  input  1  when 1, use the accumulator in place of cmd_a.
REQ-011 SHALL have port calc_op  output  3  opcode driven to the combinational calculator.
REQ-012 SHALL have ports calc_a and calc_b  output  W each  operands driven to the calculator.
REQ-013 SHALL have port calc_r  input  W  calculator result.
REQ-014 SHALL have port calc_ovf  input  1  calculator overflow flag.
REQ-015 SHALL have port res_valid  output  1  result available.
REQ-016 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-017 SHALL have ports res_data  output  W  and res_ovf  output  1  the registered result and its overflow flag.
REQ-018 SHALL have port ovf_count  output  8  saturating count of sampled overflows.
REQ-019 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-020 SHALL implement the FSM IDLE -> DRIVE -> RESP -> IDLE; there are no other states.
REQ-021 SHALL assert cmd_ready only in IDLE; a handshake (cmd_valid && cmd_ready) latches op, A and B and moves the FSM to DRIVE.
REQ-022 SHALL latch A as the acc register when cmd_acc=1, and as cmd_a otherwise.
REQ-023 SHALL drive calc_op, calc_a and calc_b from registers only; they change only on an accepting edge and hold their last values in every other state.
REQ-024 SHALL remain in DRIVE for exactly SETTLE cycles, tracked by a 4-bit down-counter.
REQ-025 SHALL, on the edge that ends DRIVE, register calc_r into res_data, calc_ovf into res_ovf, and calc_r into acc, then move the FSM to RESP.
REQ-026 SHALL make res_valid rise after the SETTLE-th rising edge following the accepting edge.
REQ-027 SHALL hold res_valid=1 and keep res_data and res_ovf stable in RESP until res_ready=1; the FSM then moves to IDLE and res_valid=0 from the next cycle.
REQ-028 SHALL ignore cmd_valid when not in IDLE; a command arriving in the same cycle as the RESP exit is accepted no earlier than the following cycle.
REQ-029 SHALL increment ovf_count by 1 on each sample with calc_ovf=1, saturating at 255 with no wrap.
REQ-030 SHALL treat arithmetic as W-bit two's complement; the block performs no arithmetic other than the counter and the SETTLE countdown.

Reset
REQ-031 SHALL, while rst=1, asynchronously force the FSM to IDLE and cmd_ready=1, and clear res_valid, res_data, res_ovf, acc, ovf_count, calc_op, calc_a, calc_b, busy and the settle counter to 0.
REQ-032 SHALL drop any in-flight command on reset mid-DRIVE or mid-RESP; no res_valid pulse is produced for it.

Structure
REQ-033 SHALL place the opcode localparams (OP_ADD_AB, OP_SUB_AB, OP_ABS_B, OP_ADD_BA, OP_SUB_BA, OP_ABS_A) and the FSM state encoding in the shared package calc_pkg.
REQ-034 SHALL implement the saturating overflow counter as one sub-module, calc_sat_counter (8-bit, enable input, saturates at 255).
REQ-035 SHALL not instantiate a calculator; the testbench connects the team's combinational calculator between calc_* outputs and calc_r/calc_ovf.

Verification (W=16, SETTLE=1, calculator in loop)
REQ-036 SHALL test: op=000, a=0x0003, b=0x0004 -> res_data=0x0007, res_ovf=0, res_valid rises on the first edge after DRIVE.
REQ-037 SHALL test: after REQ-036, cmd_acc=1, op=001, b=0x0002 -> calc_a=0x0007, res_data=0x0005.
REQ-038 SHALL test: op=000, a=0x7FFF, b=0x0001 -> res_data=0x8000, res_ovf=1, ovf_count=1; repeat 300 times -> ovf_count=255.
REQ-039 SHALL test: hold res_ready=0 for 10 cycles in RESP -> res_valid, res_data and calc_* stable, cmd_ready=0, and a concurrent cmd_valid is not accepted.
REQ-040 SHALL test: assert rst during DRIVE -> all outputs 0 immediately, cmd_ready=1, and no res_valid afterwards.
REQ-041 SHALL test: op=110, a=0x8000 -> res_ovf=1; op=010, b=0xFFFB -> res_data=0x0005, res_ovf=0.

Source files
------------

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes and FSM encoding for the calculator sequencer
package calc_pkg;

  // Opcodes understood by the external combinational calculator
  localparam logic [2:0] OP_ADD_AB = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_ABS_B  = 3'b010;
  localparam logic [2:0] OP_ADD_BA = 3'b100;
  localparam logic [2:0] OP_SUB_BA = 3'b101;
  localparam logic [2:0] OP_ABS_A  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/calc_sat_counter.sv
// rtl/calc_sat_counter.sv - 8-bit event counter that sticks at 255
module calc_sat_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic [7:0] count
);

  // Count enabled events, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (en && (count != 8'hFF)) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - sequences one command through an external calculator
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int W      = 16,
  parameter int SETTLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic         cmd_acc,
  output logic [2:0]   calc_op,
  output logic [W-1:0] calc_a,
  output logic [W-1:0] calc_b,
  input  logic [W-1:0] calc_r,
  input  logic         calc_ovf,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_ovf,
  output logic [7:0]   ovf_count,
  output logic         busy
);

  // The countdown starts at SETTLE-1 so DRIVE lasts exactly SETTLE cycles
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t       state;
  state_t       state_nx;
  logic         accept;
  logic         sample;
  logic [3:0]   settle_cnt;
  logic [W-1:0] acc;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign res_valid = (state == ST_RESP);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic plus the accept/sample strobes for the datapath
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    sample   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          accept   = 1'b1;
          state_nx = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (settle_cnt == 4'd0) begin
          sample   = 1'b1;
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Operand latch, settle countdown and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_op    <= 3'd0;
      calc_a     <= '0;
      calc_b     <= '0;
      settle_cnt <= 4'd0;
      res_data   <= '0;
      res_ovf    <= 1'b0;
      acc        <= '0;
    end else begin
      if (accept) begin
        calc_op    <= cmd_op;
        calc_a     <= cmd_acc ? acc : cmd_a;
        calc_b     <= cmd_b;
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == ST_DRIVE) && (settle_cnt != 4'd0)) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (sample) begin
        res_data <= calc_r;
        res_ovf  <= calc_ovf;
        acc      <= calc_r;
      end
    end
  end

  calc_sat_counter u_ovf_counter (
    .clk   (clk),
    .rst   (rst),
    .en    (sample && calc_ovf),
    .count (ovf_count)
  );

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - directed bench with the calculator in the loop
module tb_calc_sequencer;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_a = 16'd0;
  logic [15:0] cmd_b = 16'd0;
  logic        cmd_acc = 1'b0;
  logic [2:0]  calc_op;
  logic [15:0] calc_a;
  logic [15:0] calc_b;
  logic [15:0] calc_r;
  logic        calc_ovf;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic        res_ovf;
  logic [7:0]  ovf_count;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  calc_sequencer #(.W(16), .SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_acc   (cmd_acc),
    .calc_op   (calc_op),
    .calc_a    (calc_a),
    .calc_b    (calc_b),
    .calc_r    (calc_r),
    .calc_ovf  (calc_ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovf   (res_ovf),
    .ovf_count (ovf_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Combinational calculator between the sequencer's calc_* ports
  always_comb begin
    calc_r   = 16'd0;
    calc_ovf = 1'b0;
    case (calc_op)
      OP_ADD_AB, OP_ADD_BA: begin
        calc_r   = calc_a + calc_b;
        calc_ovf = (calc_a[15] == calc_b[15]) && (calc_r[15] != calc_a[15]);
      end
      OP_SUB_AB: begin
        calc_r   = calc_a - calc_b;
        calc_ovf = (calc_a[15] != calc_b[15]) && (calc_r[15] != calc_a[15]);
      end
      OP_SUB_BA: begin
        calc_r   = calc_b - calc_a;
        calc_ovf = (calc_a[15] != calc_b[15]) && (calc_r[15] != calc_b[15]);
      end
      OP_ABS_B, 3'b011: begin
        calc_r   = calc_b[15] ? 16'(-calc_b) : calc_b;
        calc_ovf = (calc_b == 16'h8000);
      end
      default: begin
        calc_r   = calc_a[15] ? 16'(-calc_a) : calc_a;
        calc_ovf = (calc_a == 16'h8000);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command; lat counts rising edges from DRIVE entry to res_valid
  task automatic run_cmd(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic acc, input bit release_resp,
                         output int lat, output logic [15:0] data, output logic ovf);
    int n;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_acc   = acc;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!res_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = res_data;
    ovf  = res_ovf;
    if (release_resp) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
  endtask

  initial begin
    int          lat;
    logic [15:0] data;
    logic        ovf;
    int          seen;

    // Reset state while rst is held
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_ovf_count", 32'(ovf_count), 32'd0);
    rst = 1'b0;

    // 3 + 4, with latency check
    run_cmd(3'b000, 16'h0003, 16'h0004, 1'b0, 1'b1, lat, data, ovf);
    check("add_data", 32'(data), 32'h0007);
    check("add_ovf",  32'(ovf),  32'd0);
    check("add_lat",  32'(lat),  32'd1);
    check("add_released", 32'(res_valid), 32'd0);

    // acc - 2 using the previous result as A
    run_cmd(3'b001, 16'h1234, 16'h0002, 1'b1, 1'b1, lat, data, ovf);
    check("acc_calc_a", 32'(calc_a), 32'h0007);
    check("acc_data",   32'(data),   32'h0005);

    // Signed overflow and saturating counter
    run_cmd(3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, lat, data, ovf);
    check("ovf_data",  32'(data),      32'h8000);
    check("ovf_flag",  32'(ovf),       32'd1);
    check("ovf_count1", 32'(ovf_count), 32'd1);
    for (int i = 0; i < 299; i++) begin
      run_cmd(3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, lat, data, ovf);
    end
    check("ovf_count_sat", 32'(ovf_count), 32'd255);

    // Backpressure in RESP with a competing command
    run_cmd(3'b100, 16'h0010, 16'h0020, 1'b0, 1'b0, lat, data, ovf);
    check("bp_data", 32'(data), 32'h0030);
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_a     = 16'h1111;
    cmd_b     = 16'h2222;
    cmd_acc   = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_data",  32'(res_data),  32'h0030);
      check("bp_calc_op",   32'(calc_op),   32'h4);
      check("bp_calc_a",    32'(calc_a),    32'h0010);
      check("bp_calc_b",    32'(calc_b),    32'h0020);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check("bp_exit_valid", 32'(res_valid), 32'd0);
    check("bp_exit_ready", 32'(cmd_ready), 32'd1);
    check("bp_exit_calc_a", 32'(calc_a), 32'h0010);
    cmd_valid = 1'b0;

    // abs(A) of the most negative value, abs(B) of -5
    run_cmd(3'b110, 16'h8000, 16'h0000, 1'b0, 1'b1, lat, data, ovf);
    check("absa_data", 32'(data), 32'h8000);
    check("absa_ovf",  32'(ovf),  32'd1);
    run_cmd(3'b010, 16'h0000, 16'hFFFB, 1'b0, 1'b1, lat, data, ovf);
    check("absb_data", 32'(data), 32'h0005);
    check("absb_ovf",  32'(ovf),  32'd0);
    check("absb_count", 32'(ovf_count), 32'd255);

    // Reset mid-DRIVE
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'b000;
    cmd_a     = 16'h0001;
    cmd_b     = 16'h0001;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("drv_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_cmd_ready", 32'(cmd_ready), 32'd1);
    check("ar_busy",      32'(busy),      32'd0);
    check("ar_res_valid", 32'(res_valid), 32'd0);
    check("ar_res_data",  32'(res_data),  32'd0);
    check("ar_res_ovf",   32'(res_ovf),   32'd0);
    check("ar_ovf_count", 32'(ovf_count), 32'd0);
    check("ar_calc_op",   32'(calc_op),   32'd0);
    check("ar_calc_a",    32'(calc_a),    32'd0);
    check("ar_calc_b",    32'(calc_b),    32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    check("ar_no_result", 32'(seen), 32'd0);

    // Accumulator was cleared by reset: 0 + 5
    run_cmd(3'b000, 16'hAAAA, 16'h0005, 1'b1, 1'b1, lat, data, ovf);
    check("ar_acc_data", 32'(data), 32'h0005);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
